// File: rtl/debouncer_multi_if.sv
// Purpose: bundles the button pins and the conditioned per-channel outputs of debouncer_multi.
// Latency: none, wires only.
// Backpressure: none; levels and single-cycle pulses, no handshake.
// Ports: btn_raw (pins to conditioner); btn_clean, btn_rise, btn_fall, btn_toggle, long_press
//        (conditioner to controller). Bit i of every field is channel i.
interface debouncer_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] btn_clean;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_toggle;
    logic [N_CH-1:0] long_press;

    // master: the board/controller side that drives the pins and consumes the results
    modport master (
        output btn_raw,
        input  btn_clean,
        input  btn_rise,
        input  btn_fall,
        input  btn_toggle,
        input  long_press
    );

    // slave: the conditioner itself
    modport slave (
        input  btn_raw,
        output btn_clean,
        output btn_rise,
        output btn_fall,
        output btn_toggle,
        output long_press
    );
endinterface

// File: rtl/debouncer_multi.sv
// Purpose: N-channel push-button conditioner: 2-FF sync, restart-on-glitch debounce, edge/toggle/long-press.
// Latency: clean step on btn_raw reaches btn_clean/btn_rise/btn_fall on the DB_TICKS+2 th clk edge.
// Backpressure: none; outputs are free-running levels and 1-cycle pulses.
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries btn_raw in and
//        btn_clean, btn_rise, btn_fall, btn_toggle, long_press out, one bit per channel.
module debouncer_multi #(
    parameter int N_CH       = 4,
    parameter int DB_TICKS   = 1000000,
    parameter int HOLD_TICKS = 50000000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    debouncer_multi_if.slave bus
);
    localparam int CW = $clog2(DB_TICKS);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] clean_q;
    logic [N_CH-1:0] rise_q;
    logic [N_CH-1:0] fall_q;
    logic [N_CH-1:0] toggle_q;
    logic [N_CH-1:0] long_q;
    logic [CW-1:0]   db_cnt   [N_CH];
    logic [HW-1:0]   hold_cnt [N_CH];

    // Polarity is normalised after the synchroniser so every later stage sees 1 = pressed.
    assign s = sync2 ^ {N_CH{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchroniser parks at the idle pin level so release of reset produces no false edge.
            sync1    <= {N_CH{ACTIVE_LOW}};
            sync2    <= {N_CH{ACTIVE_LOW}};
            clean_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            toggle_q <= '0;
            long_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < N_CH; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                long_q[i] <= 1'b0;
                // Toggle follows the registered rise pulse, so it flips one cycle after it.
                toggle_q[i] <= toggle_q[i] ^ rise_q[i];

                // Any sample agreeing with the accepted level restarts the count.
                if (s[i] == clean_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] < DB_LAST) begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end else begin
                    db_cnt[i]  <= '0;
                    clean_q[i] <= s[i];
                    rise_q[i]  <= s[i];
                    fall_q[i]  <= ~s[i];
                end

                // Saturating hold counter; the pulse fires only on the step into saturation,
                // which gives at most one long_press per press.
                if (!clean_q[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_MAX) begin
                    hold_cnt[i] <= hold_cnt[i] + HW'(1);
                    long_q[i]   <= (hold_cnt[i] == HOLD_LAST);
                end
            end
        end
    end

    assign bus.btn_clean  = clean_q;
    assign bus.btn_rise   = rise_q;
    assign bus.btn_fall   = fall_q;
    assign bus.btn_toggle = toggle_q;
    assign bus.long_press = long_q;
endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
Parametrised N-channel push-button conditioner for the display board. It replaces the single-channel pause debouncer with one block serving all front-panel buttons (pause, speed, direction, ...). Per channel it provides:
- 2-FF synchroniser
- restart-on-glitch stability counter
- clean level, rise and fall pulses, toggle latch and long-press pulse

Sits between the board pins and the display controller FSM. All outputs are synchronous to clk.

Parameters:
- N_CH, 4, number of independent button channels.
- DB_TICKS, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz). Must be >= 2.
- HOLD_TICKS, 50000000, cycles the clean level must stay pressed to fire long_press (1 s at 50 MHz). Must be > DB_TICKS.
- ACTIVE_LOW, 0, 1 = buttons are active-low; inputs are inverted after synchronisation.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_CH  asynchronous, noisy button inputs; bit i = channel i.
- btn_clean  out  N_CH  debounced level, 1 = pressed, regardless of ACTIVE_LOW.
- btn_rise  out  N_CH  1-cycle pulse when btn_clean goes 0->1.
- btn_fall  out  N_CH  1-cycle pulse when btn_clean goes 1->0.
- btn_toggle  out  N_CH  level that inverts on every btn_rise.
- long_press  out  N_CH  1-cycle pulse once per press after HOLD_TICKS cycles of continuous press.

Behaviour:
- Reset:
  - Applied on a clk edge with rst=1.
  - Clears btn_clean, btn_rise, btn_fall, btn_toggle and long_press to 0.
  - Clears every counter to 0.
  - Sets synchroniser flops to the inactive raw level (0 if ACTIVE_LOW=0, 1 if ACTIVE_LOW=1).
  - Reset asserted mid-count or mid-press discards all progress. No pulse is generated by reset itself.
- Synchroniser: 2 flops per channel. s_i = sync2_i XOR ACTIVE_LOW.
- Debounce counter: one per channel, width $clog2(DB_TICKS). Each cycle:
  - s_i == btn_clean_i: cnt_i <= 0.
  - s_i != btn_clean_i and cnt_i < DB_TICKS-1: cnt_i <= cnt_i+1.
  - s_i != btn_clean_i and cnt_i == DB_TICKS-1: btn_clean_i <= s_i, cnt_i <= 0.
  - Any bounce back to the old level before acceptance restarts the count from 0.
- Latency: a clean step on btn_raw_i changes btn_clean_i on the (DB_TICKS+2)th rising clk edge after the step.
- Edge pulses:
  - btn_rise_i / btn_fall_i are registered and asserted in the same cycle btn_clean_i takes its new value.
  - Each is high for exactly 1 cycle. Rise and fall are never both high on one channel.
- Toggle: btn_toggle_i inverts one cycle after each btn_rise_i pulse; it is unaffected by btn_fall_i.
- Long-press counter: one per channel, width $clog2(HOLD_TICKS+1).
  - Cleared while btn_clean_i=0.
  - Increments while btn_clean_i=1, saturating at HOLD_TICKS.
  - long_press_i pulses for 1 cycle in the cycle the counter goes from HOLD_TICKS-1 to HOLD_TICKS, i.e. HOLD_TICKS cycles after btn_rise_i.
  - At most one pulse per press. Release and re-press re-arms it.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- No combinational path from btn_raw to any output.

Test Plan:
Bench parameters: N_CH=2, DB_TICKS=8, HOLD_TICKS=32, ACTIVE_LOW=0.
- Reset: hold rst for 3 cycles with btn_raw=2'b11 -> all outputs 0 during and 1 cycle after reset; btn_clean[0]=1 exactly DB_TICKS+2=10 edges after rst deasserts.
- Clean press on ch0: btn_raw[0] 0->1 held -> btn_clean[0]=1 and btn_rise[0]=1 on edge 10; btn_rise[0]=0 on edge 11; btn_toggle[0]=1 on edge 11; ch1 outputs stay 0.
- Bounce: btn_raw[0] high 5 cycles, low 2, high 5, low 1, then high steady -> no btn_rise[0] until 10 edges after the final rising step; exactly one rise pulse.
- Long press: hold ch1 for 50 cycles -> long_press[1] pulses once, 32 cycles after btn_rise[1]; release -> btn_fall[1] 10 edges later; second press re-arms the pulse; two rises leave btn_toggle[1]=0.
- Simultaneous and reset-mid-operation: step both channels together -> btn_rise=2'b11 in the same cycle; assert rst at cnt=5 of a press -> no pulse, outputs 0, and after release of rst a full 10 edges is needed.
- ACTIVE_LOW=1 rerun: btn_raw idle at 2'b11 after reset -> outputs stay 0; btn_raw[0] 1->0 -> btn_clean[0]=1 after 10 edges.
